// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcode constants, FSM state type
// and a helper that flags the opcodes using the carry chain.
package serial_alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ADD and SUB are the only ops that produce meaningful cout/ovf.
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice used once per clock by the serial ALU.
// Ports: a, b, cin  - operand bits and incoming carry
//        op         - opcode (SUB inverts b internally)
//        y, cout    - result bit and outgoing carry (0 for logic ops)
module alu1
  import serial_alu_pkg::*;
(
  input  logic            a,
  input  logic            b,
  input  logic            cin,
  input  logic [OP_W-1:0] op,
  output logic            y,
  output logic            cout
);

  logic b_eff;

  // Full adder shared by ADD and SUB; unused opcodes yield zero.
  always_comb begin
    b_eff = (op == OP_SUB) ? ~b : b;
    y     = 1'b0;
    cout  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        y    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (cin & (a ^ b_eff));
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: processes WIDTH-bit operands LSB first, one bit per clock.
// Ports: clk, rst (sync, active-high)
//        start, op, a, b  - request and operands, captured when IDLE or DONE
//        busy             - high during the WIDTH processing cycles
//        done             - one-cycle pulse with a fresh result
//        y, cout, zero, ovf - result and flags, held between done pulses
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q;
  logic [OP_W-1:0]  op_q;
  logic             carry_q;
  logic [WIDTH-1:0] y_q;
  logic             cout_q, zero_q, ovf_q;

  logic             accept_c, last_c;
  logic             bit_y_c, bit_cout_c;
  logic [WIDTH-1:0] res_next_c;

  assign accept_c   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_c     = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  assign res_next_c = {bit_y_c, res_sr_q[WIDTH-1:1]};

  alu1 u_alu1 (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .y    (bit_y_c),
    .cout (bit_cout_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_c) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand/result shift registers, carry, counter, result regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      y_q      <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else if (accept_c) begin
      cnt_q    <= '0;
      a_sr_q   <= a;
      b_sr_q   <= b;
      op_q     <= op;
      // SUB is a + ~b + 1: the +1 enters as the initial carry.
      carry_q  <= (op == OP_SUB);
    end else if (state_q == ST_RUN) begin
      a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
      res_sr_q <= res_next_c;
      carry_q  <= bit_cout_c;
      if (last_c) begin
        // carry_q here is the carry into the MSB, bit_cout_c the carry out.
        y_q    <= res_next_c;
        zero_q <= (res_next_c == '0);
        cout_q <= is_arith(op_q) & bit_cout_c;
        ovf_q  <= is_arith(op_q) & (carry_q ^ bit_cout_c);
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign y    = y_q;
  assign cout = cout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu (WIDTH = 8): the driver pushes expected
// results from an arithmetic reference model; a monitor pops on every done.
module tb_serial_alu;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] y;
    logic         cout;
    logic         zero;
    logic         ovf;
    int unsigned  cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] y;
  logic         cout, zero, ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  bit          mon_en = 1'b0;
  exp_t        q[$];
  exp_t        last;

  serial_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .cout  (cout),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference model straight from the arithmetic definitions.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    exp_t       e;
    logic [W:0] s;
    e.y = '0; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = 0;
    case (o)
      3'd0: begin
        s = {1'b0, x} + {1'b0, z};
        e.y = s[W-1:0]; e.cout = s[W];
        e.ovf = (x[W-1] == z[W-1]) && (e.y[W-1] != x[W-1]);
      end
      3'd1: begin
        s = {1'b0, x} + {1'b0, ~z} + (W+1)'(1);
        e.y = s[W-1:0]; e.cout = s[W];
        e.ovf = (x[W-1] != z[W-1]) && (e.y[W-1] != x[W-1]);
      end
      3'd2: e.y = x & z;
      3'd3: e.y = x | z;
      3'd4: e.y = x ^ z;
      3'd5: e.y = ~x;
      default: e.y = '0;
    endcase
    e.zero = (e.y == '0);
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.y = '0; e.cout = 1'b0; e.zero = 1'b1; e.ovf = 1'b0; e.cyc = 0;
    return e;
  endfunction

  // Drive a start on the current negedge and record the expected result.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    exp_t e;
    start = 1'b1; op = o; a = x; b = z;
    e = model(o, x, z);
    e.cyc = cyc + 1 + W;
    q.push_back(e);
  endtask

  task automatic check_reset();
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_zero", 64'(zero), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
  endtask

  // One operation from IDLE; optionally pulse start once during RUN (at glitch_at).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                        input int unsigned glitch_at);
    @(negedge clk);
    issue(o, x, z);
    for (int unsigned k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      start = (k == glitch_at);
      if (k == glitch_at) begin
        op = 3'($urandom_range(0, 7));
        a  = W'($urandom);
        b  = W'($urandom);
      end
      if (k == 1) chk("busy_in_run", 64'(busy), 64'(1));
      if (k == W + 1) chk("busy_in_done", 64'(busy), 64'(0));
    end
  endtask

  // Monitor: compare on every done, otherwise outputs must hold.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("busy_done_excl", 64'(busy & done), 64'(0));
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("y", 64'(y), 64'(e.y));
          chk("cout", 64'(cout), 64'(e.cout));
          chk("zero", 64'(zero), 64'(e.zero));
          chk("ovf", 64'(ovf), 64'(e.ovf));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          last = e;
        end
      end else begin
        chk("hold_y", 64'(y), 64'(last.y));
        chk("hold_flags", 64'({cout, zero, ovf}), 64'({last.cout, last.zero, last.ovf}));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    last = reset_exp();
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases.
    run_op(3'b000, 8'hFF, 8'h01, 0);
    run_op(3'b000, 8'h7F, 8'h01, 0);
    run_op(3'b001, 8'h05, 8'h07, 0);
    run_op(3'b100, 8'hA5, 8'hFF, 0);
    run_op(3'b101, 8'h0F, 8'h00, 0);
    run_op(3'b010, 8'hF0, 8'h3C, 0);
    run_op(3'b011, 8'hF0, 8'h0F, 0);
    run_op(3'b110, 8'hAB, 8'hCD, 0);
    run_op(3'b111, 8'h12, 8'h34, 0);
    run_op(3'b001, 8'h80, 8'h01, 0);

    // Start during RUN must be ignored.
    run_op(3'b000, 8'h12, 8'h34, 3);

    // Reset mid-operation: no done, reset values, then a normal op.
    @(negedge clk);
    issue(3'b000, 8'h55, 8'h66);
    repeat (4) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    rst = 1'b1;
    q.delete();
    last = reset_exp();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_reset();
    repeat (W + 2) @(negedge clk);
    run_op(3'b001, 8'h10, 8'h20, 0);

    // Back-to-back: start held through DONE.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      repeat (W + 1) @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    // Random operations, some with an ignored start during RUN.
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), $urandom_range(0, W));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (W + 4) @(negedge clk);
    chk("drain_pending", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 Port: start  input  1  operation request, sampled on rising clk.
REQ-005 Port: op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A; 110/111 produce zero result.
REQ-006 Port: a  input  WIDTH  operand A, captured on accepted start.
REQ-007 Port: b  input  WIDTH  operand B, captured on accepted start.
REQ-008 Port: busy  output  1  high while a bit-serial operation is in progress.
REQ-009 Port: done  output  1  single-cycle pulse marking a valid new result.
REQ-010 Port: y  output  WIDTH  result, held stable between done pulses.
REQ-011 Port: cout  output  1  final carry for ADD; final carry (1 = no borrow) for SUB; 0 otherwise.
REQ-012 Port: zero  output  1  high when y == 0.
REQ-013 Port: ovf  output  1  signed overflow for ADD/SUB (carry into MSB XOR carry out of MSB); 0 otherwise.

Function
REQ-014 FSM states IDLE, RUN, DONE; encoding is free.
REQ-015 Start is accepted only when the state is IDLE or DONE; an accepted start latches a, b and op, clears the bit counter, and enters RUN.
REQ-016 Start while in RUN is ignored; latched operands and op are unaffected.
REQ-017 Processing is LSB first, one bit per clock, over WIDTH clocks in RUN.
REQ-018 Carry register init: 0 for ADD, 1 for SUB, 0 for all other ops.
REQ-019 SUB computes a + ~b + 1 using the same adder path with B inverted per bit.
REQ-020 Each bit of RUN computes result bit i and the next carry from a[i], b[i] (inverted for SUB), carry, and the latched op.
REQ-021 After the bit with index WIDTH-1 is processed, the state goes to DONE.
REQ-022 The bit counter is $clog2(WIDTH) bits wide and the state never wraps past WIDTH-1.
REQ-023 On DONE entry, y, cout, zero and ovf update together; they do not change during RUN.
REQ-024 DONE lasts one cycle, then goes to IDLE, unless start is high in DONE, which goes to RUN (back-to-back).
REQ-025 busy = 1 exactly in RUN; done = 1 exactly in DONE.
REQ-026 Latency: if start is sampled at edge E, then busy is high for the cycles after E through E+WIDTH-1, and done is high in the cycle after edge E+WIDTH.
REQ-027 For op 110/111, the block still runs WIDTH cycles; the result is y = 0, zero = 1, cout = 0, ovf = 0.

Reset
REQ-028 rst high at a clock edge forces IDLE and sets y = 0, cout = 0, ovf = 0, zero = 1, busy = 0, done = 0, and clears the counter and carry.
REQ-029 rst during RUN aborts the operation with no done pulse; the aborted result is discarded.
REQ-030 rst takes priority over start in the same cycle.

Structure
REQ-031 A shared package holds the opcode constants (OP_ADD..OP_NOT) and the FSM state typedef.
REQ-032 The block has one sub-module, alu1 (1-bit slice: a, b, cin, op -> y, cout), extended with opcode 001 SUB, which inverts b internally.
REQ-033 Operand shift registers, the result shift register, the carry flop, the counter and the FSM live in serial_alu.

Verification (WIDTH = 8)
REQ-034 ADD a = 0xFF, b = 0x01 -> y = 0x00, cout = 1, zero = 1, ovf = 0; done exactly 9 cycles after the start edge.
REQ-035 ADD 0x7F + 0x01 -> y = 0x80, ovf = 1, cout = 0; SUB 0x05 - 0x07 -> y = 0xFE, cout = 0, ovf = 0.
REQ-036 XOR 0xA5, 0xFF -> 0x5A; NOT A 0x0F -> 0xF0; AND 0xF0, 0x3C -> 0x30; OR 0xF0, 0x0F -> 0xFF; op 110 -> y = 0x00, zero = 1.
REQ-037 Start pulsed again at cycle 3 of RUN with different operands -> ignored; the original result appears; a single done pulse.
REQ-038 rst asserted at cycle 4 of RUN -> no done pulse, outputs at reset values, and the next start completes normally.
REQ-039 start held high through DONE -> back-to-back operations; done pulses spaced 9 cycles apart, each y correct.
